// File: rtl/calc_pkg.sv
// Shared types for the hex calculator sequencing controller.
// Operator codes, controller states and the datapath width.
package calc_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_AND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_CALC = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/calc_mul_iter.sv
// Iterative shift-add multiplier, one step per clock.
// Ports: start_i/a_i/b_i begin a run, abort_i kills it, done_o/prod_o report it.
module calc_mul_iter
  import calc_pkg::*;
#(
  parameter int STEPS = DATA_W
) (
  input  logic                clk_g,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  input  logic                abort_i,
  output logic                done_o,
  output logic [2*DATA_W-1:0] prod_o
);

  localparam int CW = $clog2(STEPS + 1);

  logic [2*DATA_W-1:0] acc_q;
  logic [DATA_W-1:0]   a_q;
  logic [CW-1:0]       cnt_q;
  logic                run_q;

  // Low half holds the remaining multiplier bits; the high half
  // accumulates and everything shifts right once per step.
  function automatic logic [2*DATA_W-1:0] step(
    input logic [2*DATA_W-1:0] acc,
    input logic [DATA_W-1:0]   a
  );
    logic [DATA_W:0] s;
    s = {1'b0, acc[2*DATA_W-1:DATA_W]}
      + (acc[0] ? {1'b0, a} : '0);
    return {s, acc[DATA_W-1:1]};
  endfunction

  // The start cycle performs the first step, so the final step
  // lands one edge before the controller consumes the product.
  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      a_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (abort_i) begin
      run_q <= 1'b0;
    end else if (start_i) begin
      acc_q <= step({{DATA_W{1'b0}}, b_i}, a_i);
      a_q   <= a_i;
      cnt_q <= CW'(1);
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == CW'(STEPS)) begin
        run_q <= 1'b0;
      end else begin
        acc_q <= step(acc_q, a_q);
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign done_o = run_q && (cnt_q == CW'(STEPS));
  assign prod_o = acc_q;

endmodule

// File: rtl/calc_ctrl.sv
// Hex calculator sequencer: digit entry, operator latch, calculation.
// Ports: key/op/eq/clr pulses in; disp_value/disp_load/busy/ovf out.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int MUL_STEPS = 32
) (
  input  logic              clk_g,
  input  logic              rst_n,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  input  logic              op_valid,
  input  logic [1:0]        op_code,
  input  logic              eq_valid,
  input  logic              clr_valid,
  output logic [DATA_W-1:0] disp_value,
  output logic              disp_load,
  output logic              busy,
  output logic              ovf
);

  localparam int CW = $clog2(DIGITS + 1);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   disp_q, disp_d;
  logic                load_q, load_d;
  logic                busy_q, busy_d;
  logic                ovf_q, ovf_d;

  logic                full_w;
  logic [DATA_W:0]     sum_w, dif_w;
  logic                mul_start;
  logic                mul_done;
  logic [2*DATA_W-1:0] prod_w;

  assign full_w = (cnt_q == CW'(DIGITS));
  assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
  assign dif_w  = {1'b0, a_q} - {1'b0, b_q};

  calc_mul_iter #(
    .STEPS(MUL_STEPS)
  ) u_mul (
    .clk_g  (clk_g),
    .rst_n  (rst_n),
    .start_i(mul_start),
    .a_i    (a_q),
    .b_i    (b_q),
    .abort_i(clr_valid),
    .done_o (mul_done),
    .prod_o (prod_w)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    disp_d    = disp_q;
    load_d    = 1'b0;
    ovf_d     = ovf_q;
    mul_start = 1'b0;

    if (clr_valid) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      disp_d  = '0;
      load_d  = 1'b1;
    end else begin
      unique case (state_q)
        S_A: begin
          if (op_valid) begin
            op_d    = op_e'(op_code);
            b_d     = '0;
            cnt_d   = '0;
            state_d = S_B;
          end else if (key_valid && !full_w) begin
            a_d    = {a_q[DATA_W-5:0], key_code};
            cnt_d  = cnt_q + CW'(1);
            disp_d = a_d;
            load_d = 1'b1;
          end
        end
        S_B: begin
          if (op_valid) begin
            op_d = op_e'(op_code);
          end else if (eq_valid) begin
            state_d   = S_CALC;
            mul_start = (op_q == OP_MUL);
          end else if (key_valid && !full_w) begin
            b_d    = {b_q[DATA_W-5:0], key_code};
            cnt_d  = cnt_q + CW'(1);
            disp_d = b_d;
            load_d = 1'b1;
          end
        end
        S_CALC: begin
          if (op_q != OP_MUL || mul_done) begin
            state_d = S_DONE;
            load_d  = 1'b1;
            unique case (op_q)
              OP_ADD: begin
                a_d   = sum_w[DATA_W-1:0];
                ovf_d = sum_w[DATA_W];
              end
              OP_SUB: begin
                a_d   = dif_w[DATA_W-1:0];
                ovf_d = dif_w[DATA_W];
              end
              OP_MUL: begin
                a_d   = prod_w[DATA_W-1:0];
                ovf_d = |prod_w[2*DATA_W-1:DATA_W];
              end
              OP_AND: begin
                a_d   = a_q & b_q;
                ovf_d = 1'b0;
              end
            endcase
            disp_d = a_d;
          end
        end
        S_DONE: begin
          if (op_valid) begin
            op_d    = op_e'(op_code);
            b_d     = '0;
            cnt_d   = '0;
            state_d = S_B;
          end else if (eq_valid) begin
            state_d   = S_CALC;
            mul_start = (op_q == OP_MUL);
          end else if (key_valid) begin
            a_d     = {{(DATA_W-4){1'b0}}, key_code};
            cnt_d   = CW'(1);
            disp_d  = a_d;
            load_d  = 1'b1;
            state_d = S_A;
          end
        end
      endcase
    end

    busy_d = (state_d == S_CALC);
  end

  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_A;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign disp_value = disp_q;
  assign disp_load  = load_q;
  assign busy       = busy_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed self-checking bench for calc_ctrl.
// Drives key/op/eq/clr pulses on negedges and checks results.
module tb_calc_ctrl;

  logic        clk_g = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = 2'b00;
  logic        eq_valid = 1'b0;
  logic        clr_valid = 1'b0;
  logic [31:0] disp_value;
  logic        disp_load;
  logic        busy;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  int loads  = 0;

  always #5 clk_g = ~clk_g;

  calc_ctrl dut (
    .clk_g     (clk_g),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .op_valid  (op_valid),
    .op_code   (op_code),
    .eq_valid  (eq_valid),
    .clr_valid (clr_valid),
    .disp_value(disp_value),
    .disp_load (disp_load),
    .busy      (busy),
    .ovf       (ovf)
  );

  always @(negedge clk_g) if (disp_load) loads++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic key_p(input logic [3:0] k);
    @(negedge clk_g);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk_g);
    key_valid = 1'b0;
    #1;
  endtask

  task automatic keys(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) key_p(v[i*4 +: 4]);
  endtask

  task automatic op_p(input logic [1:0] o);
    @(negedge clk_g);
    op_valid = 1'b1;
    op_code  = o;
    @(negedge clk_g);
    op_valid = 1'b0;
    #1;
  endtask

  task automatic clr_p();
    @(negedge clk_g);
    clr_valid = 1'b1;
    @(negedge clk_g);
    clr_valid = 1'b0;
    #1;
  endtask

  // Edges from the eq edge (counted as 1) to the edge that raises
  // disp_load; -1 when the result never arrives.
  task automatic eq_run(output int lat, output int bcyc);
    lat  = -1;
    bcyc = 0;
    @(negedge clk_g);
    eq_valid = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk_g);
      eq_valid = 1'b0;
      if (busy) bcyc++;
      if (disp_load) begin
        lat = n;
        break;
      end
    end
    #1;
  endtask

  int lat, bcyc, l0;

  initial begin
    #1;
    chk("rst_disp", disp_value, 32'h0);
    chk("rst_load", {31'b0, disp_load}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_ovf", {31'b0, ovf}, 32'h0);
    @(negedge clk_g);
    rst_n = 1'b1;

    l0 = loads;
    keys(32'h123, 3);
    chk("k123_disp", disp_value, 32'h0000_0123);
    chk("k123_loads", loads - l0, 3);
    chk("k123_busy", {31'b0, busy}, 32'h0);

    clr_p();
    chk("clr_disp", disp_value, 32'h0);
    keys(32'hFFFF_FFFF, 8);
    op_p(2'b00);
    keys(32'h2, 1);
    eq_run(lat, bcyc);
    chk("add_disp", disp_value, 32'h0000_0001);
    chk("add_ovf", {31'b0, ovf}, 32'h1);
    chk("add_lat", lat, 2);
    chk("add_busy", bcyc, 1);
    chk("add_busy_after", {31'b0, busy}, 32'h0);

    clr_p();
    keys(32'h3, 1);
    op_p(2'b01);
    keys(32'h5, 1);
    eq_run(lat, bcyc);
    chk("sub_disp", disp_value, 32'hFFFF_FFFE);
    chk("sub_ovf", {31'b0, ovf}, 32'h1);
    eq_run(lat, bcyc);
    chk("sub2_disp", disp_value, 32'hFFFF_FFF9);
    chk("sub2_ovf", {31'b0, ovf}, 32'h0);

    clr_p();
    keys(32'h10000, 5);
    op_p(2'b10);
    keys(32'h10000, 5);
    eq_run(lat, bcyc);
    chk("mul_disp", disp_value, 32'h0);
    chk("mul_ovf", {31'b0, ovf}, 32'h1);
    chk("mul_busy", bcyc, 32);
    chk("mul_lat", lat, 33);

    clr_p();
    keys(32'h1234, 4);
    op_p(2'b10);
    keys(32'h10, 2);
    eq_run(lat, bcyc);
    chk("mul2_disp", disp_value, 32'h0001_2340);
    chk("mul2_ovf", {31'b0, ovf}, 32'h0);

    op_p(2'b11);
    keys(32'hF0F0, 4);
    eq_run(lat, bcyc);
    chk("and_disp", disp_value, 32'h0000_2040);
    chk("and_ovf", {31'b0, ovf}, 32'h0);
    chk("and_lat", lat, 2);

    clr_p();
    keys(32'h7, 1);
    op_p(2'b10);
    keys(32'h9, 1);
    @(negedge clk_g);
    eq_valid = 1'b1;
    @(negedge clk_g);
    eq_valid = 1'b0;
    repeat (8) @(negedge clk_g);
    clr_valid = 1'b1;
    @(negedge clk_g);
    clr_valid = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_disp", disp_value, 32'h0);
    chk("abort_load", {31'b0, disp_load}, 32'h1);
    l0 = loads;
    repeat (40) @(negedge clk_g);
    #1;
    chk("abort_noload", loads - l0, 0);
    keys(32'h4, 1);
    chk("abort_sa", disp_value, 32'h4);

    clr_p();
    l0 = loads;
    keys(32'h1234_5678, 8);
    chk("dig8_disp", disp_value, 32'h1234_5678);
    chk("dig8_loads", loads - l0, 8);
    keys(32'h9, 1);
    chk("dig9_disp", disp_value, 32'h1234_5678);
    chk("dig9_loads", loads - l0, 8);

    clr_p();
    keys(32'hA, 1);
    l0 = loads;
    @(negedge clk_g);
    key_valid = 1'b1;
    key_code  = 4'h5;
    op_valid  = 1'b1;
    op_code   = 2'b00;
    @(negedge clk_g);
    key_valid = 1'b0;
    op_valid  = 1'b0;
    #1;
    chk("keyop_disp", disp_value, 32'hA);
    chk("keyop_noload", loads - l0, 0);
    keys(32'h3, 1);
    eq_run(lat, bcyc);
    chk("keyop_res", disp_value, 32'hD);
    keys(32'h7, 1);
    chk("done_key", disp_value, 32'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
